// File: rtl/mips_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control path.
package mips_pkg;

  localparam int unsigned STATE_W = 4;
  localparam int unsigned ALU_W   = 3;
  localparam int unsigned OP_W    = 6;

  typedef enum logic [STATE_W-1:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    RTYPEEX = 4'd6,
    RTYPEWB = 4'd7,
    IMMEX   = 4'd8,
    IMMWB   = 4'd9,
    BEQEX   = 4'd10,
    BNEEX   = 4'd11,
    JEX     = 4'd12
  } state_t;

  typedef enum logic [ALU_W-1:0] {
    ALU_AND = 3'd0,
    ALU_OR  = 3'd1,
    ALU_ADD = 3'd2,
    ALU_SLL = 3'd3,
    ALU_SRL = 3'd4,
    ALU_SRA = 3'd5,
    ALU_SUB = 3'd6,
    ALU_SLT = 3'd7
  } alu_op_t;

  // Opcodes (instruction[31:26])
  localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
  localparam logic [OP_W-1:0] OP_J     = 6'b000010;
  localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
  localparam logic [OP_W-1:0] OP_BNE   = 6'b000101;
  localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
  localparam logic [OP_W-1:0] OP_SLTI  = 6'b001010;
  localparam logic [OP_W-1:0] OP_ANDI  = 6'b001100;
  localparam logic [OP_W-1:0] OP_ORI   = 6'b001101;
  localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
  localparam logic [OP_W-1:0] OP_SW    = 6'b101011;

  // Funct codes (instruction[5:0])
  localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
  localparam logic [OP_W-1:0] FN_SUB = 6'b100010;
  localparam logic [OP_W-1:0] FN_AND = 6'b100100;
  localparam logic [OP_W-1:0] FN_OR  = 6'b100101;
  localparam logic [OP_W-1:0] FN_SLT = 6'b101010;
  localparam logic [OP_W-1:0] FN_SLL = 6'b000000;
  localparam logic [OP_W-1:0] FN_SRL = 6'b000010;
  localparam logic [OP_W-1:0] FN_SRA = 6'b000011;

  // Datapath mux encodings
  localparam logic [1:0] SRC_A_PC    = 2'b00;
  localparam logic [1:0] SRC_A_REG_A = 2'b01;
  localparam logic [1:0] SRC_A_REG_B = 2'b10;

  localparam logic [2:0] SRC_B_REG_B    = 3'b000;
  localparam logic [2:0] SRC_B_FOUR     = 3'b001;
  localparam logic [2:0] SRC_B_SIGN_IMM = 3'b010;
  localparam logic [2:0] SRC_B_IMM_SH2  = 3'b011;
  localparam logic [2:0] SRC_B_SHAMT    = 3'b100;
  localparam logic [2:0] SRC_B_ZERO_IMM = 3'b101;

  localparam logic [1:0] PC_SRC_ALU    = 2'b00;
  localparam logic [1:0] PC_SRC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_SRC_JUMP   = 2'b10;

  // Per-state control word held in the output register
  typedef struct packed {
    logic             pc_write;
    logic             branch_eq;
    logic             branch_ne;
    logic             iord;
    logic             mem_write;
    logic             ir_write;
    logic             reg_dst;
    logic             mem_to_reg;
    logic             reg_write;
    logic [1:0]       alu_src_a;
    logic [2:0]       alu_src_b;
    logic [ALU_W-1:0] alu_control;
    logic [1:0]       pc_src;
  } ctrl_t;

  // Shift ops take rt on A and shamt on B
  function automatic logic is_shift(input logic [ALU_W-1:0] op);
    return op inside {ALU_SLL, ALU_SRL, ALU_SRA};
  endfunction

endpackage

// File: rtl/multi_controller_alu_decoder.sv
// ALU operation decode from funct (R-type) or opcode (immediate ops).
module alu_decoder
  import mips_pkg::*;
(
  input  logic [5:0] funct_i,
  input  logic [5:0] op_i,
  input  logic       imm_i,
  output logic [2:0] alu_control_o,
  output logic       supported_o
);

  // Map funct or immediate opcode onto the ALU code
  always_comb begin
    alu_control_o = ALU_ADD;
    supported_o   = 1'b0;
    if (imm_i) begin
      case (op_i)
        OP_ADDI: begin alu_control_o = ALU_ADD; supported_o = 1'b1; end
        OP_SLTI: begin alu_control_o = ALU_SLT; supported_o = 1'b1; end
        OP_ANDI: begin alu_control_o = ALU_AND; supported_o = 1'b1; end
        OP_ORI:  begin alu_control_o = ALU_OR;  supported_o = 1'b1; end
        default: ;
      endcase
    end else begin
      case (funct_i)
        FN_ADD: begin alu_control_o = ALU_ADD; supported_o = 1'b1; end
        FN_SUB: begin alu_control_o = ALU_SUB; supported_o = 1'b1; end
        FN_AND: begin alu_control_o = ALU_AND; supported_o = 1'b1; end
        FN_OR:  begin alu_control_o = ALU_OR;  supported_o = 1'b1; end
        FN_SLT: begin alu_control_o = ALU_SLT; supported_o = 1'b1; end
        FN_SLL: begin alu_control_o = ALU_SLL; supported_o = 1'b1; end
        FN_SRL: begin alu_control_o = ALU_SRL; supported_o = 1'b1; end
        FN_SRA: begin alu_control_o = ALU_SRA; supported_o = 1'b1; end
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/multi_controller.sv
// Moore control FSM for the multi-cycle MIPS core.
module multi_controller
  import mips_pkg::*;
#(
  parameter state_t RESET_STATE = FETCH
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [5:0] op_i,
  input  logic [5:0] funct_i,
  input  logic       zero_i,
  output logic       pc_en_o,
  output logic       iord_o,
  output logic       mem_write_o,
  output logic       ir_write_o,
  output logic       reg_dst_o,
  output logic       mem_to_reg_o,
  output logic       reg_write_o,
  output logic [1:0] alu_src_a_o,
  output logic [2:0] alu_src_b_o,
  output logic [2:0] alu_control_o,
  output logic [1:0] pc_src_o,
  output logic [3:0] state_o
);

  logic [ALU_W-1:0] dec_alu;
  logic             dec_supported;
  logic             imm_sel;
  state_t           state_q;
  state_t           state_n;
  ctrl_t            ctrl_q;

  assign imm_sel = (op_i != OP_RTYPE);

  alu_decoder u_alu_decoder (
    .funct_i       (funct_i),
    .op_i          (op_i),
    .imm_i         (imm_sel),
    .alu_control_o (dec_alu),
    .supported_o   (dec_supported)
  );

  // Successor state; unsupported ops and stray encodings fall back to FETCH
  function automatic state_t next_state(input state_t s, input logic [5:0] op,
                                        input logic rtype_ok);
    state_t n;
    n = FETCH;
    case (s)
      FETCH:   n = DECODE;
      DECODE: begin
        case (op)
          OP_LW, OP_SW:                       n = MEMADR;
          OP_RTYPE:                           n = rtype_ok ? RTYPEEX : FETCH;
          OP_BEQ:                             n = BEQEX;
          OP_BNE:                             n = BNEEX;
          OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI:  n = IMMEX;
          OP_J:                               n = JEX;
          default:                            n = FETCH;
        endcase
      end
      MEMADR: begin
        if (op == OP_LW)      n = MEMRD;
        else if (op == OP_SW) n = MEMWR;
        else                  n = FETCH;
      end
      MEMRD:   n = MEMWB;
      RTYPEEX: n = RTYPEWB;
      IMMEX:   n = IMMWB;
      default: n = FETCH;
    endcase
    return n;
  endfunction

  // Control word for a state; EX states pick up the decoded ALU op
  function automatic ctrl_t ctrl_for(input state_t s, input logic [5:0] op,
                                     input logic [ALU_W-1:0] alu);
    ctrl_t c;
    c = '0;
    c.alu_control = ALU_ADD;
    case (s)
      FETCH: begin
        c.ir_write  = 1'b1;
        c.alu_src_b = SRC_B_FOUR;
        c.pc_write  = 1'b1;
      end
      DECODE:  c.alu_src_b = SRC_B_IMM_SH2;
      MEMADR: begin
        c.alu_src_a = SRC_A_REG_A;
        c.alu_src_b = SRC_B_SIGN_IMM;
      end
      MEMRD:   c.iord = 1'b1;
      MEMWB: begin
        c.mem_to_reg = 1'b1;
        c.reg_write  = 1'b1;
      end
      MEMWR: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
      end
      RTYPEEX: begin
        c.alu_control = alu;
        if (is_shift(alu)) begin
          c.alu_src_a = SRC_A_REG_B;
          c.alu_src_b = SRC_B_SHAMT;
        end else begin
          c.alu_src_a = SRC_A_REG_A;
          c.alu_src_b = SRC_B_REG_B;
        end
      end
      RTYPEWB: begin
        c.reg_dst   = 1'b1;
        c.reg_write = 1'b1;
      end
      IMMEX: begin
        c.alu_src_a   = SRC_A_REG_A;
        c.alu_src_b   = (op == OP_ANDI || op == OP_ORI) ? SRC_B_ZERO_IMM : SRC_B_SIGN_IMM;
        c.alu_control = alu;
      end
      IMMWB:   c.reg_write = 1'b1;
      BEQEX, BNEEX: begin
        c.alu_src_a   = SRC_A_REG_A;
        c.alu_src_b   = SRC_B_REG_B;
        c.alu_control = ALU_SUB;
        c.pc_src      = PC_SRC_ALUOUT;
        c.branch_eq   = (s == BEQEX);
        c.branch_ne   = (s == BNEEX);
      end
      JEX: begin
        c.pc_src   = PC_SRC_JUMP;
        c.pc_write = 1'b1;
      end
      default: ;
    endcase
    return c;
  endfunction

  assign state_n = next_state(state_q, op_i, dec_supported);

  // State register plus registered control word for the state being entered
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= RESET_STATE;
      ctrl_q  <= ctrl_for(RESET_STATE, op_i, dec_alu);
    end else begin
      state_q <= state_n;
      ctrl_q  <= ctrl_for(state_n, op_i, dec_alu);
    end
  end

  assign pc_en_o       = ctrl_q.pc_write | (ctrl_q.branch_eq & zero_i) |
                         (ctrl_q.branch_ne & ~zero_i);
  assign iord_o        = ctrl_q.iord;
  assign mem_write_o   = ctrl_q.mem_write;
  assign ir_write_o    = ctrl_q.ir_write;
  assign reg_dst_o     = ctrl_q.reg_dst;
  assign mem_to_reg_o  = ctrl_q.mem_to_reg;
  assign reg_write_o   = ctrl_q.reg_write;
  assign alu_src_a_o   = ctrl_q.alu_src_a;
  assign alu_src_b_o   = ctrl_q.alu_src_b;
  assign alu_control_o = ctrl_q.alu_control;
  assign pc_src_o      = ctrl_q.pc_src;
  assign state_o       = state_q;

endmodule

// File: tb/tb_multi_controller.sv
// Randomized instruction-stream bench for multi_controller with a per-instruction reference model.
module tb_multi_controller;
  import mips_pkg::*;

  logic       clk;
  logic       rst_i;
  logic [5:0] op_i;
  logic [5:0] funct_i;
  logic       zero_i;
  logic       pc_en_o;
  logic       iord_o;
  logic       mem_write_o;
  logic       ir_write_o;
  logic       reg_dst_o;
  logic       mem_to_reg_o;
  logic       reg_write_o;
  logic [1:0] alu_src_a_o;
  logic [2:0] alu_src_b_o;
  logic [2:0] alu_control_o;
  logic [1:0] pc_src_o;
  logic [3:0] state_o;

  multi_controller dut (
    .clk_i         (clk),
    .rst_i         (rst_i),
    .op_i          (op_i),
    .funct_i       (funct_i),
    .zero_i        (zero_i),
    .pc_en_o       (pc_en_o),
    .iord_o        (iord_o),
    .mem_write_o   (mem_write_o),
    .ir_write_o    (ir_write_o),
    .reg_dst_o     (reg_dst_o),
    .mem_to_reg_o  (mem_to_reg_o),
    .reg_write_o   (reg_write_o),
    .alu_src_a_o   (alu_src_a_o),
    .alu_src_b_o   (alu_src_b_o),
    .alu_control_o (alu_control_o),
    .pc_src_o      (pc_src_o),
    .state_o       (state_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // How pc_en is expected to behave in a cycle
  localparam logic [1:0] BR_NONE = 2'd0, BR_ALWAYS = 2'd1, BR_EQ = 2'd2, BR_NE = 2'd3;

  typedef struct packed {
    state_t     st;
    logic       iord;
    logic       mw;
    logic       irw;
    logic       rdst;
    logic       m2r;
    logic       rw;
    logic [1:0] sa;
    logic [2:0] sb;
    logic [2:0] alu;
    logic [1:0] ps;
    logic [1:0] br;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s at %0t: got %0h, expected %0h", tag, $time, got, exp);
    end
  endtask

  function automatic exp_t blank(input state_t s);
    exp_t e;
    e     = '0;
    e.st  = s;
    e.alu = 3'd2;
    return e;
  endfunction

  // ALU code for a funct; -1 for a funct the core does not decode
  function automatic int funct_alu(input logic [5:0] f);
    case (f)
      6'b100000: return 2;
      6'b100010: return 6;
      6'b100100: return 0;
      6'b100101: return 1;
      6'b101010: return 7;
      6'b000000: return 3;
      6'b000010: return 4;
      6'b000011: return 5;
      default:   return -1;
    endcase
  endfunction

  // Instruction latency in cycles, FETCH inclusive
  function automatic int latency_of(input logic [5:0] op, input logic [5:0] f);
    case (op)
      6'b100011: return 5;
      6'b101011, 6'b001000, 6'b001010, 6'b001100, 6'b001101: return 4;
      6'b000000: return (funct_alu(f) >= 0) ? 4 : 2;
      6'b000100, 6'b000101, 6'b000010: return 3;
      default:   return 2;
    endcase
  endfunction

  // Expected cycle-by-cycle control for one instruction
  function automatic void build(input logic [5:0] op, input logic [5:0] f);
    exp_t e;
    int   a;
    exp_q.delete();
    e = blank(FETCH);  e.irw = 1'b1; e.sb = 3'b001; e.br = BR_ALWAYS; exp_q.push_back(e);
    e = blank(DECODE); e.sb = 3'b011; exp_q.push_back(e);
    a = -1;
    case (op)
      6'b100011, 6'b101011: begin
        e = blank(MEMADR); e.sa = 2'b01; e.sb = 3'b010; exp_q.push_back(e);
        if (op == 6'b100011) begin
          e = blank(MEMRD); e.iord = 1'b1; exp_q.push_back(e);
          e = blank(MEMWB); e.m2r = 1'b1; e.rw = 1'b1; exp_q.push_back(e);
        end else begin
          e = blank(MEMWR); e.iord = 1'b1; e.mw = 1'b1; exp_q.push_back(e);
        end
      end
      6'b000000: begin
        a = funct_alu(f);
        if (a >= 0) begin
          e = blank(RTYPEEX); e.alu = 3'(a);
          if (a == 3 || a == 4 || a == 5) begin e.sa = 2'b10; e.sb = 3'b100; end
          else                            begin e.sa = 2'b01; e.sb = 3'b000; end
          exp_q.push_back(e);
          e = blank(RTYPEWB); e.rdst = 1'b1; e.rw = 1'b1; exp_q.push_back(e);
        end
      end
      6'b000100, 6'b000101: begin
        e = blank(op == 6'b000100 ? BEQEX : BNEEX);
        e.sa = 2'b01; e.alu = 3'd6; e.ps = 2'b01;
        e.br = (op == 6'b000100) ? BR_EQ : BR_NE;
        exp_q.push_back(e);
      end
      6'b001000, 6'b001010, 6'b001100, 6'b001101: begin
        e = blank(IMMEX); e.sa = 2'b01;
        case (op)
          6'b001000: begin e.alu = 3'd2; e.sb = 3'b010; end
          6'b001010: begin e.alu = 3'd7; e.sb = 3'b010; end
          6'b001100: begin e.alu = 3'd0; e.sb = 3'b101; end
          default:   begin e.alu = 3'd1; e.sb = 3'b101; end
        endcase
        exp_q.push_back(e);
        e = blank(IMMWB); e.rw = 1'b1; exp_q.push_back(e);
      end
      6'b000010: begin
        e = blank(JEX); e.ps = 2'b10; e.br = BR_ALWAYS; exp_q.push_back(e);
      end
      default: ;
    endcase
  endfunction

  task automatic check_step(input exp_t e);
    logic pe;
    case (e.br)
      BR_ALWAYS: pe = 1'b1;
      BR_EQ:     pe = zero_i;
      BR_NE:     pe = ~zero_i;
      default:   pe = 1'b0;
    endcase
    check_eq("state",       32'(state_o),       32'(e.st));
    check_eq("pc_en",       32'(pc_en_o),       32'(pe));
    check_eq("iord",        32'(iord_o),        32'(e.iord));
    check_eq("mem_write",   32'(mem_write_o),   32'(e.mw));
    check_eq("ir_write",    32'(ir_write_o),    32'(e.irw));
    check_eq("reg_dst",     32'(reg_dst_o),     32'(e.rdst));
    check_eq("mem_to_reg",  32'(mem_to_reg_o),  32'(e.m2r));
    check_eq("reg_write",   32'(reg_write_o),   32'(e.rw));
    check_eq("alu_src_a",   32'(alu_src_a_o),   32'(e.sa));
    check_eq("alu_src_b",   32'(alu_src_b_o),   32'(e.sb));
    check_eq("alu_control", 32'(alu_control_o), 32'(e.alu));
    check_eq("pc_src",      32'(pc_src_o),      32'(e.ps));
  endtask

  // Runs one instruction starting at a negedge in FETCH; zmode 0 random, 1 zero=1, 2 zero=0
  task automatic run_instr(input logic [5:0] op, input logic [5:0] f, input int zmode);
    int lat;
    build(op, f);
    op_i    = op;
    funct_i = f;
    lat     = 0;
    for (int i = 0; i < exp_q.size(); i++) begin
      zero_i = (zmode == 1) ? 1'b1 : (zmode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
      #1;
      check_step(exp_q[i]);
      if (i > 0 && state_o == FETCH && lat == 0) lat = i;
      @(negedge clk);
    end
    if (lat == 0 && state_o == FETCH) lat = exp_q.size();
    check_eq("latency", 32'(lat), 32'(latency_of(op, f)));
  endtask

  function automatic logic [5:0] pick_op();
    case ($urandom_range(0, 12))
      0:       return 6'b100011;
      1:       return 6'b101011;
      2, 3, 4: return 6'b000000;
      5:       return 6'b000100;
      6:       return 6'b000101;
      7:       return 6'b001000;
      8:       return 6'b001010;
      9:       return 6'b001100;
      10:      return 6'b001101;
      11:      return 6'b000010;
      default: return 6'($urandom);
    endcase
  endfunction

  function automatic logic [5:0] pick_funct();
    case ($urandom_range(0, 9))
      0:       return 6'b100000;
      1:       return 6'b100010;
      2:       return 6'b100100;
      3:       return 6'b100101;
      4:       return 6'b101010;
      5:       return 6'b000000;
      6:       return 6'b000010;
      7:       return 6'b000011;
      default: return 6'($urandom);
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_i   = 1'b1;
    op_i    = 6'd0;
    funct_i = 6'd0;
    zero_i  = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b0;

    // Directed cases from the ISA table
    run_instr(6'b100011, 6'b000000, 0);   // lw
    run_instr(6'b101011, 6'b111111, 0);   // sw
    run_instr(6'b000000, 6'b000011, 0);   // sra
    run_instr(6'b000000, 6'b100000, 0);   // add
    run_instr(6'b000000, 6'b101010, 0);   // slt
    run_instr(6'b000100, 6'b000000, 1);   // beq taken
    run_instr(6'b000100, 6'b000000, 2);   // beq not taken
    run_instr(6'b000101, 6'b000000, 1);   // bne not taken
    run_instr(6'b000101, 6'b000000, 2);   // bne taken
    run_instr(6'b001101, 6'b000000, 0);   // ori
    run_instr(6'b001010, 6'b000000, 0);   // slti
    run_instr(6'b111111, 6'b000000, 0);   // undefined op
    run_instr(6'b000000, 6'b001000, 0);   // unsupported funct
    run_instr(6'b000010, 6'b000000, 0);   // j

    // Reset while an lw sits in MEMRD
    op_i    = 6'b100011;
    funct_i = 6'd0;
    repeat (3) @(negedge clk);
    #1;
    check_eq("pre_reset_state", 32'(state_o), 32'(MEMRD));
    rst_i = 1'b1;
    @(negedge clk);
    rst_i  = 1'b0;
    zero_i = 1'b0;
    #1;
    check_eq("rst_state",     32'(state_o),     32'(FETCH));
    check_eq("rst_ir_write",  32'(ir_write_o),  32'd1);
    check_eq("rst_pc_en",     32'(pc_en_o),     32'd1);
    check_eq("rst_reg_write", 32'(reg_write_o), 32'd0);
    check_eq("rst_mem_write", 32'(mem_write_o), 32'd0);
    op_i = 6'b111111;
    @(negedge clk);
    #1;
    check_eq("rst_no_memwb",  32'(state_o),     32'(DECODE));
    check_eq("rst_reg_write2", 32'(reg_write_o), 32'd0);
    @(negedge clk);

    // Random instruction stream
    for (int k = 0; k < 300; k++) begin
      logic [5:0] rop;
      logic [5:0] rf;
      rop = pick_op();
      rf  = pick_funct();
      run_instr(rop, rf, 0);
    end

    #1;
    check_eq("final_state", 32'(state_o), 32'(FETCH));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
